// File: rtl/bit_permute_unit.sv
// Sequential bit reorder unit: reverse, rotate left/right by a latched amount
// (one bit per cycle), or pass-through, with a START/BUSY/DONE handshake.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | waiting for start; operands are latched on the accepting edge
// S_RUN  | rotating one bit per edge, or committing the result
// S_FIN  | done pulse; outdata holds the new result
module bit_permute_unit #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] indata,
   output logic [WIDTH-1:0] outdata,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIN  = 2'b10
   } state_t;

   localparam logic [1:0] M_REV  = 2'b00;
   localparam logic [1:0] M_ROL  = 2'b01;
   localparam logic [1:0] M_ROR  = 2'b10;
   localparam logic [1:0] M_PASS = 2'b11;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] work;
   logic [1:0]       mode_r;
   logic [AMT_W-1:0] cnt;

   logic             load;
   logic             rot;
   logic             commit;
   logic [WIDTH-1:0] rev_w;
   logic [WIDTH-1:0] rot_w;
   logic [WIDTH-1:0] res_w;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      rot      = 1'b0;
      commit   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            if ((mode_r == M_ROL || mode_r == M_ROR) && cnt != '0) begin
               rot = 1'b1;
            end else begin
               commit   = 1'b1;
               state_nx = S_FIN;
            end
         end
         S_FIN:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      rev_w = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rev_w[i] = work[WIDTH-1-i];
      end
   end

   always_comb begin
      rot_w = work;
      if (mode_r == M_ROL) rot_w = {work[WIDTH-2:0], work[WIDTH-1]};
      else                 rot_w = {work[0], work[WIDTH-1:1]};
   end

   // PASS and finished rotates both deliver the work register unchanged
   assign res_w = (mode_r == M_REV) ? rev_w : work;

   always_ff @(posedge clk) begin
      if (reset) begin
         work    <= '0;
         mode_r  <= M_REV;
         cnt     <= '0;
         outdata <= '0;
      end else begin
         if (load) begin
            work   <= indata;
            mode_r <= mode;
            cnt    <= amount;
         end
         if (rot) begin
            work <= rot_w;
            cnt  <= cnt - AMT_W'(1);
         end
         if (commit) outdata <= res_w;
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_FIN);

   logic unused_pass;
   assign unused_pass = (M_PASS == 2'b11);

endmodule

// File: tb/tb_bit_permute_unit.sv
// Bench for bit_permute_unit: directed scenarios plus randomized operations on
// 8-bit and 16-bit instances, checked against an arithmetic reference model.
module tb_bit_permute_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start8 = 1'b0;
   logic        start16 = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [3:0]  amount = 4'd0;
   logic [15:0] indata = 16'd0;
   logic [7:0]  out8;
   logic        busy8, done8;
   logic [15:0] out16;
   logic        busy16, done16;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bit_permute_unit #(.WIDTH(8), .AMT_W(3)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .mode(mode),
      .amount(amount[2:0]), .indata(indata[7:0]),
      .outdata(out8), .busy(busy8), .done(done8)
   );

   bit_permute_unit #(.WIDTH(16), .AMT_W(4)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .mode(mode),
      .amount(amount), .indata(indata),
      .outdata(out16), .busy(busy16), .done(done16)
   );

   // Rotation written as shift/or arithmetic on the mathematical amount.
   function automatic logic [31:0] ref_perm(input logic [1:0] m, input int unsigned n,
                                            input logic [31:0] x_in, input int w);
      logic [31:0] mask, x, r;
      int k;
      mask = (32'h1 << w) - 32'h1;
      x = x_in & mask;
      r = x;
      k = 0;
      case (m)
         2'b00: begin
            r = 32'h0;
            for (int i = 0; i < w; i++) if (x[i]) r[w-1-i] = 1'b1;
         end
         2'b01: k = int'(n % w);
         2'b10: k = int'((w - (n % w)) % w);
         default: r = x;
      endcase
      if ((m == 2'b01 || m == 2'b10) && k != 0) r = ((x << k) | (x >> (w - k))) & mask;
      return r;
   endfunction

   function automatic int ref_lat(input logic [1:0] m, input int unsigned n);
      return (m == 2'b01 || m == 2'b10) ? int'(n) + 2 : 2;
   endfunction

   function automatic logic [31:0] cur_out(input int w);
      return (w == 8) ? {24'h0, out8} : {16'h0, out16};
   endfunction
   function automatic logic cur_busy(input int w);
      return (w == 8) ? busy8 : busy16;
   endfunction
   function automatic logic cur_done(input int w);
      return (w == 8) ? done8 : done16;
   endfunction

   task automatic set_start(input int w, input logic v);
      if (w == 8) start8 = v;
      else        start16 = v;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered and left at #1 after a rising edge with the DUT idle.
   task automatic run_op(input int w, input logic [1:0] m, input int unsigned n,
                         input logic [15:0] d, input string tag, input bit scramble);
      logic [31:0] prev, exp;
      int cyc;
      bit seen;
      prev = cur_out(w);
      exp  = ref_perm(m, n, {16'h0, d}, w);
      mode = m; amount = n[3:0]; indata = d;
      set_start(w, 1'b1);
      @(posedge clk); #1;
      set_start(w, 1'b0);
      cyc = 1;
      seen = cur_done(w);
      while (!seen && cyc < 40) begin
         chk({tag, "/busy_run"}, {31'h0, cur_busy(w)}, 32'h1);
         chk({tag, "/out_hold"}, cur_out(w), prev);
         if (scramble) begin
            mode = 2'($urandom); amount = 4'($urandom); indata = 16'($urandom);
            set_start(w, 1'($urandom));
         end
         @(posedge clk); #1;
         cyc++;
         seen = cur_done(w);
      end
      set_start(w, 1'b0);
      chk({tag, "/latency"}, cyc, ref_lat(m, n));
      chk({tag, "/result"}, cur_out(w), exp);
      chk({tag, "/busy_fin"}, {31'h0, cur_busy(w)}, 32'h1);
      @(posedge clk); #1;
      chk({tag, "/done_pulse"}, {31'h0, cur_done(w)}, 32'h0);
      chk({tag, "/busy_idle"}, {31'h0, cur_busy(w)}, 32'h0);
      chk({tag, "/out_keep"}, cur_out(w), exp);
   endtask

   initial begin
      int cyc;
      int w;
      int unsigned n;

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst/out8", {24'h0, out8}, 32'h0);
      chk("rst/busy8", {31'h0, busy8}, 32'h0);
      chk("rst/done8", {31'h0, done8}, 32'h0);
      chk("rst/out16", {16'h0, out16}, 32'h0);
      chk("rst/busy16", {31'h0, busy16}, 32'h0);
      chk("rst/done16", {31'h0, done16}, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_op(8, 2'b00, 0, 16'h00C5, "rev_c5", 1'b0);
      chk("rev_c5/const", {24'h0, out8}, 32'hA3);
      run_op(8, 2'b01, 3, 16'h0081, "rol3_81", 1'b0);
      chk("rol3_81/const", {24'h0, out8}, 32'h0C);
      run_op(8, 2'b10, 7, 16'h0001, "ror7_01", 1'b0);
      chk("ror7_01/const", {24'h0, out8}, 32'h02);
      run_op(8, 2'b01, 0, 16'h005A, "rol0_5a", 1'b0);
      chk("rol0_5a/const", {24'h0, out8}, 32'h5A);
      run_op(8, 2'b11, 0, 16'h00E7, "pass_e7", 1'b0);

      // start held high, operand changed mid-run, back-to-back with idle gap
      mode = 2'b01; amount = 4'd3; indata = 16'h0081; start8 = 1'b1;
      @(posedge clk); #1;
      indata = 16'h00FF;
      cyc = 1;
      while (!done8 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("b2b/lat1", cyc, 5);
      chk("b2b/res1", {24'h0, out8}, 32'h0C);
      @(posedge clk); #1;
      chk("b2b/gap_busy", {31'h0, busy8}, 32'h0);
      chk("b2b/gap_out", {24'h0, out8}, 32'h0C);
      @(posedge clk); #1;
      start8 = 1'b0;
      chk("b2b/second_busy", {31'h0, busy8}, 32'h1);
      cyc = 1;
      while (!done8 && cyc < 40) begin
         chk("b2b/hold", {24'h0, out8}, 32'h0C);
         @(posedge clk); #1;
         cyc++;
      end
      chk("b2b/lat2", cyc, 5);
      chk("b2b/res2", {24'h0, out8}, ref_perm(2'b01, 3, 32'hFF, 8));
      @(posedge clk); #1;

      // reset two cycles into a long rotate
      mode = 2'b01; amount = 4'd7; indata = 16'h0096; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort/busy", {31'h0, busy8}, 32'h0);
      chk("abort/done", {31'h0, done8}, 32'h0);
      chk("abort/out", {24'h0, out8}, 32'h0);
      run_op(8, 2'b11, 0, 16'h003C, "pass_3c", 1'b0);
      chk("pass_3c/const", {24'h0, out8}, 32'h3C);

      run_op(16, 2'b00, 0, 16'h0001, "rev16_0001", 1'b0);
      chk("rev16/const", {16'h0, out16}, 32'h8000);
      run_op(16, 2'b10, 15, 16'h8000, "ror16_15", 1'b0);
      chk("ror16/const", {16'h0, out16}, 32'h0001);

      repeat (40) begin
         w = ($urandom_range(0, 1) == 0) ? 8 : 16;
         n = $urandom_range(0, w - 1);
         run_op(w, 2'($urandom), n, 16'($urandom), (w == 8) ? "rand8" : "rand16", 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
